mnist_mem_scheduler: RTL and testbench

Sequencer and arbiter for the 28x28 image memory (784 words x 32 bit) that backs the drawing grid. Four agents share the memory's single access slot per cycle:
- a clear engine that zeroes the grid;
- the keyboard draw writer;
- a ready/valid pixel stream feeding the neural-network inference datapath;
- the VGA refresh reader.

The block sits between those agents and `image_memory`; the top level ties `image_memory.write_addr` and `.read_addr` both to `mem_addr`.

---
 rtl/mnist_pkg.sv | 17 +
 rtl/mnist_mem_scheduler_stream_fifo2.sv | 58 +++++
 rtl/mnist_mem_scheduler.sv | 177 +++++++++++++++++
 tb/tb_mnist_mem_scheduler.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mnist_pkg.sv
// rtl/mnist_pkg.sv - shared constants and FSM encoding for the image memory scheduler
//
// Purpose: grid geometry, pixel index width and the top-level scheduler states,
// imported by every file of the scheduler.
package mnist_pkg;

  localparam int GRID_SIZE = 28;
  localparam int DEPTH     = GRID_SIZE * GRID_SIZE;
  localparam int IDX_W     = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_STREAM = 2'd2
  } state_t;

endpackage

// File: rtl/mnist_mem_scheduler_stream_fifo2.sv
// rtl/mnist_mem_scheduler_stream_fifo2.sv - two-entry FIFO for tagged stream pixels
//
// Purpose: holds pixel words returned by the memory until the inference
// datapath accepts them. Entry e0 is always the head.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   push, din     write an entry (caller guarantees room)
//   pop           drop the head (caller guarantees non-empty)
//   dout          head entry
//   count         occupancy 0..2
module stream_fifo2 #(
  parameter int W = 42
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);

  logic [W-1:0] e0;
  logic [W-1:0] e1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0    <= '0;
      e1    <= '0;
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) e0 <= din;
          else               e1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          e0    <= e1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged: the new entry lands behind whatever remains
          if (count == 2'd1) begin
            e0 <= din;
          end else begin
            e0 <= e1;
            e1 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout = e0;

endmodule

// File: rtl/mnist_mem_scheduler.sv
// rtl/mnist_mem_scheduler.sv - slot arbiter and sequencer for the 28x28 image memory
//
// Purpose: shares the single memory access slot per cycle between the clear
// engine, the draw writer, the inference pixel stream and the VGA reader
// (priority in that order).
// Ports:
//   CLOCK_50, reset                 clock, asynchronous active-high reset
//   clear_req / clear_busy          zero the whole grid
//   wr_req, wr_addr, wr_data, wr_ack draw writer
//   nn_start / nn_busy, nn_valid, nn_ready, nn_data, nn_index, nn_last  pixel stream
//   disp_req, disp_addr, disp_ack, disp_valid, disp_data                display reader
//   mem_addr, mem_we, mem_wdata, mem_rdata                              image memory
module mnist_mem_scheduler #(
  parameter int GRID_SIZE = mnist_pkg::GRID_SIZE,
  parameter int DEPTH     = GRID_SIZE * GRID_SIZE,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              clear_req,
  output logic              clear_busy,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              nn_start,
  output logic              nn_busy,
  output logic              nn_valid,
  input  logic              nn_ready,
  output logic [DATA_W-1:0] nn_data,
  output logic [9:0]        nn_index,
  output logic              nn_last,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ack,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  import mnist_pkg::*;

  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [IDX_W:0]    DEPTH_I  = (IDX_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

  state_t state, state_next;
  logic clr_pend, clr_pend_next;
  logic nn_pend, nn_pend_next;

  logic [IDX_W-1:0] clr_cnt;
  logic [IDX_W:0]   rd_idx;        // one extra bit so "all issued" is representable
  logic             inflight;      // a stream read was issued last cycle
  logic [IDX_W-1:0] inflight_idx;
  logic             disp_pend;
  logic             disp_oob;

  logic [1:0]              fifo_count;
  logic [DATA_W+IDX_W-1:0] fifo_head;
  logic                    head_valid, fifo_pop, rd_space;
  logic [IDX_W-1:0]        head_idx;

  logic clr_active, wr_grant, rd_issue, disp_grant;

  assign clr_active = (state == ST_CLEAR);
  assign head_valid = (fifo_count != 2'd0);
  assign fifo_pop   = head_valid && nn_ready;
  assign head_idx   = fifo_head[DATA_W+IDX_W-1:DATA_W];

  // Occupancy is taken after this cycle's pop so a continuously ready consumer
  // gets one word per cycle while the FIFO still never exceeds two entries.
  assign rd_space = (({1'b0, fifo_count} - {2'b00, fifo_pop} + {2'b00, inflight}) < 3'd2);

  assign wr_grant   = !reset && wr_req && !clr_active;
  assign rd_issue   = !reset && (state == ST_STREAM) && (rd_idx < DEPTH_I) && !wr_grant && rd_space;
  assign disp_grant = !reset && disp_req && !clr_active && !wr_grant && !rd_issue;

  assign wr_ack   = wr_grant;
  assign disp_ack = disp_grant;

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (clr_active) begin
      mem_addr = {{(ADDR_W - IDX_W){1'b0}}, clr_cnt};
      mem_we   = 1'b1;
    end else if (wr_grant) begin
      mem_addr  = wr_addr;
      mem_we    = (wr_addr < DEPTH_A);
      mem_wdata = wr_data;
    end else if (rd_issue) begin
      mem_addr = {{(ADDR_W - IDX_W){1'b0}}, rd_idx[IDX_W-1:0]};
    end else if (disp_grant) begin
      mem_addr = disp_addr;
    end
  end

  always_comb begin
    state_next    = state;
    clr_pend_next = clr_pend;
    nn_pend_next  = nn_pend;
    case (state)
      ST_IDLE: begin
        if (clear_req || clr_pend) begin
          state_next    = ST_CLEAR;
          clr_pend_next = 1'b0;
          nn_pend_next  = nn_pend || nn_start;
        end else if (nn_start || nn_pend) begin
          state_next   = ST_STREAM;
          nn_pend_next = 1'b0;
        end
      end
      ST_CLEAR: begin
        if (nn_start) nn_pend_next = 1'b1;
        if (clr_cnt == LAST_IDX) state_next = ST_IDLE;
      end
      ST_STREAM: begin
        if (clear_req) clr_pend_next = 1'b1;
        if (fifo_pop && (head_idx == LAST_IDX)) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      clr_pend     <= 1'b0;
      nn_pend      <= 1'b0;
      clr_cnt      <= '0;
      rd_idx       <= '0;
      inflight     <= 1'b0;
      inflight_idx <= '0;
      disp_pend    <= 1'b0;
      disp_oob     <= 1'b0;
    end else begin
      state    <= state_next;
      clr_pend <= clr_pend_next;
      nn_pend  <= nn_pend_next;
      if (clr_active) clr_cnt <= (clr_cnt == LAST_IDX) ? '0 : clr_cnt + 1'b1;
      if ((state == ST_STREAM) && (state_next == ST_IDLE)) rd_idx <= '0;
      else if (rd_issue)                                  rd_idx <= rd_idx + 1'b1;
      inflight     <= rd_issue;
      inflight_idx <= rd_idx[IDX_W-1:0];
      disp_pend    <= disp_grant;
      disp_oob     <= (disp_addr >= DEPTH_A);
    end
  end

  stream_fifo2 #(.W(DATA_W + IDX_W)) u_fifo (
    .clk   (CLOCK_50),
    .rst   (reset),
    .push  (inflight),
    .pop   (fifo_pop),
    .din   ({inflight_idx, mem_rdata}),
    .dout  (fifo_head),
    .count (fifo_count)
  );

  assign nn_valid   = head_valid;
  assign nn_data    = head_valid ? fifo_head[DATA_W-1:0] : '0;
  assign nn_index   = head_valid ? head_idx : '0;
  assign nn_last    = head_valid && (head_idx == LAST_IDX);
  assign clear_busy = clr_pend || clr_active;
  assign nn_busy    = nn_pend || (state == ST_STREAM);

  // The memory's read port is itself a register, so the returned word is
  // qualified by the registered grant rather than registered a second time.
  assign disp_valid = disp_pend;
  assign disp_data  = (disp_pend && !disp_oob) ? mem_rdata : '0;

endmodule

// File: tb/tb_mnist_mem_scheduler.sv
// tb/tb_mnist_mem_scheduler.sv - self-checking bench for mnist_mem_scheduler
module tb_mnist_mem_scheduler;

  localparam int DEPTH = 784;

  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        clear_req = 1'b0, wr_req = 1'b0, nn_start = 1'b0, nn_ready = 1'b0, disp_req = 1'b0;
  logic [15:0] wr_addr = '0, disp_addr = '0;
  logic [31:0] wr_data = '0;
  logic        clear_busy, wr_ack, nn_busy, nn_valid, nn_last, disp_ack, disp_valid, mem_we;
  logic [31:0] nn_data, disp_data, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic [9:0]  nn_index;
  logic [15:0] mem_addr;

  int checks = 0;
  int errors = 0;

  logic [31:0] golden [0:DEPTH-1];
  logic [31:0] mem    [0:DEPTH-1];
  logic        load_req = 1'b0;

  mnist_mem_scheduler dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .clear_req(clear_req), .clear_busy(clear_busy),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .nn_start(nn_start), .nn_busy(nn_busy), .nn_valid(nn_valid), .nn_ready(nn_ready),
    .nn_data(nn_data), .nn_index(nn_index), .nn_last(nn_last),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_ack(disp_ack),
    .disp_valid(disp_valid), .disp_data(disp_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // image memory: synchronous write, registered read
  always @(posedge CLOCK_50) begin
    if (load_req) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= golden[i];
    end else if (mem_we && mem_addr < 16'd784) begin
      mem[mem_addr] <= mem_wdata;
    end
    mem_rdata <= (mem_addr < 16'd784) ? mem[mem_addr] : 32'd0;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_mem();
    @(posedge CLOCK_50); #2; load_req = 1'b1;
    @(posedge CLOCK_50); #2; load_req = 1'b0;
  endtask

  function automatic int mem_diff();
    int d = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== golden[i]) d++;
    return d;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_flags"}, 32'({clear_busy, nn_busy, nn_valid, nn_last, disp_valid, wr_ack, disp_ack, mem_we}), 32'd0);
    check({tag, "_addr"}, 32'({16'd0, mem_addr} | {22'd0, nn_index}), 32'd0);
    check({tag, "_data"}, mem_wdata | nn_data | disp_data, 32'd0);
  endtask

  // Drives and scores one stream against the golden image.
  // dmode: 0 no display, 1 random display reads, 2 display held on address 7.
  task automatic run_stream(input bit pulse, input bit rnd, input int dmode,
                            input int clr_at, input int abort_at);
    int exp_idx = 0, cyc = 0, first = -1, bad = 0, gap = 0, dbad = 0, dacks = 0;
    int want = (abort_at >= 0) ? abort_at + 1 : DEPTH;
    bit done = 0, pstall = 0, dpend = 0, clr_next = 0;
    logic [31:0] pd, dexp;
    logic [9:0]  pi;
    logic        pl;
    if (pulse) begin
      @(posedge CLOCK_50); #2; nn_start = 1'b1; nn_ready = 1'b1; #1;
    end
    while (!done && cyc < 4000) begin
      @(posedge CLOCK_50); #2;
      nn_start  = 1'b0;
      clear_req = clr_next;
      clr_next  = 0;
      nn_ready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (dmode == 1) begin
        disp_req  = 1'($urandom_range(0, 1));
        disp_addr = 16'($urandom_range(0, 799));
      end else if (dmode == 2) begin
        disp_req  = 1'b1;
        disp_addr = 16'd7;
      end
      #1; cyc++;
      if (dpend) begin
        if (!(disp_valid === 1'b1 && disp_data === dexp)) dbad++;
      end else if (disp_valid !== 1'b0) dbad++;
      dpend = disp_ack;
      dexp  = (disp_addr < 16'd784) ? golden[disp_addr] : 32'd0;
      if (disp_ack) begin
        dacks++;
        if (mem_we !== 1'b0 || mem_addr !== disp_addr) dbad++;
        if (dmode == 2 && exp_idx < 770) dbad++;
      end
      if (pstall && !(nn_valid === 1'b1 && nn_data === pd && nn_index === pi && nn_last === pl)) bad++;
      if (dut.u_fifo.count > 2'd2) bad++;
      if (!rnd && first >= 0 && nn_valid !== 1'b1) gap++;
      if (nn_valid && nn_ready) begin
        if (first < 0) first = cyc;
        if (nn_index !== 10'(exp_idx) || nn_data !== golden[exp_idx] ||
            nn_last !== (exp_idx == DEPTH - 1)) bad++;
        if (exp_idx == clr_at) clr_next = 1;
        exp_idx++;
        if (exp_idx == want) done = 1;
      end else if (nn_last === 1'b1 && nn_index !== 10'd783) bad++;
      pstall = nn_valid && !nn_ready;
      pd = nn_data; pi = nn_index; pl = nn_last;
    end
    disp_req = 1'b0;
    check("stream_beats", 32'(exp_idx), 32'(want));
    check("stream_order_data_stable", 32'(bad), 32'd0);
    if (!rnd) check("stream_contiguous", 32'(gap), 32'd0);
    if (dmode != 0) check("display_reads", 32'(dbad), 32'd0);
    if (dmode == 2) check("display_eventually_acked", 32'(dacks > 0), 32'd1);
    if (pulse) check("first_valid_latency", 32'(first >= 2), 32'd1);
  endtask

  initial begin
    int bad;
    // reset: combinational outputs must stay low even with requests present
    wr_req = 1'b1; disp_req = 1'b1; wr_addr = 16'd3; disp_addr = 16'd4;
    #13;
    check_zero("reset_state");
    @(posedge CLOCK_50); #2; reset = 1'b0; wr_req = 1'b0; disp_req = 1'b0;

    // clear of a grid full of ones, with a draw write held throughout
    for (int i = 0; i < DEPTH; i++) golden[i] = 32'd1;
    load_mem();
    @(posedge CLOCK_50); #2; clear_req = 1'b1; #1;
    check("clear_busy_req_cycle", 32'(clear_busy), 32'd0);
    @(posedge CLOCK_50); #2; clear_req = 1'b0; wr_req = 1'b1; wr_addr = 16'd20; wr_data = 32'd9; #1;
    bad = 0;
    for (int k = 0; k < DEPTH; k++) begin
      if (!(clear_busy === 1'b1 && mem_we === 1'b1 && mem_addr === 16'(k) &&
            mem_wdata === 32'd0 && wr_ack === 1'b0)) bad++;
      @(posedge CLOCK_50); #3;
    end
    check("clear_sequence", 32'(bad), 32'd0);
    check("clear_busy_after", 32'(clear_busy), 32'd0);
    check("wr_ack_after_clear", 32'({wr_ack, mem_we}), 32'd3);
    for (int i = 0; i < DEPTH; i++) golden[i] = 32'd0;
    golden[20] = 32'd9;
    @(posedge CLOCK_50); #2; wr_req = 1'b0; #1;
    @(posedge CLOCK_50); #3;
    check("clear_mem_contents", 32'(mem_diff()), 32'd0);

    // out-of-range draw write is acked but does not write
    @(posedge CLOCK_50); #2; wr_req = 1'b1; wr_addr = 16'd900; wr_data = 32'd5; #1;
    check("oob_write_ack_we", 32'({wr_ack, mem_we}), 32'd2);
    @(posedge CLOCK_50); #2; wr_req = 1'b0; #1;

    // full-rate stream of word i = i
    for (int i = 0; i < DEPTH; i++) golden[i] = 32'(i);
    load_mem();
    run_stream(1, 0, 0, -1, -1);
    @(posedge CLOCK_50); #3;
    check("nn_busy_end", 32'(nn_busy), 32'd0);

    // random data, random backpressure, random display traffic
    for (int i = 0; i < DEPTH; i++) golden[i] = $urandom;
    load_mem();
    run_stream(1, 1, 1, -1, -1);

    // collision: draw write, stream read and display read in one cycle
    for (int i = 0; i < DEPTH; i++) golden[i] = 32'(i);
    load_mem();
    @(posedge CLOCK_50); #2; nn_start = 1'b1; nn_ready = 1'b1; #1;
    @(posedge CLOCK_50); #2; nn_start = 1'b0; wr_req = 1'b1; wr_addr = 16'd5; wr_data = 32'd1;
    disp_req = 1'b1; disp_addr = 16'd7; #1;
    check("collision_grant", 32'({wr_ack, disp_ack, mem_we}), 32'b101);
    check("collision_addr", 32'(mem_addr), 32'd5);
    golden[5] = 32'd1;
    @(posedge CLOCK_50); #2; wr_req = 1'b0; #1;
    check("collision_disp_loses_to_stream", 32'(disp_ack), 32'd0);
    run_stream(0, 0, 2, -1, -1);

    // clear requested mid-stream, stream requested mid-clear
    for (int i = 0; i < DEPTH; i++) golden[i] = $urandom;
    load_mem();
    run_stream(1, 0, 0, 100, -1);
    check("clear_pending_after_stream", 32'(clear_busy), 32'd1);
    for (int i = 0; i < DEPTH; i++) golden[i] = 32'd0;
    for (int w = 0; w < 10 && !mem_we; w++) begin @(posedge CLOCK_50); #3; end
    check("pending_clear_started", 32'(mem_we), 32'd1);
    @(posedge CLOCK_50); #2; nn_start = 1'b1; #1;
    @(posedge CLOCK_50); #2; nn_start = 1'b0; #1;
    check("stream_pending_in_clear", 32'({nn_busy, clear_busy, nn_valid}), 32'b110);
    for (int w = 0; w < 1000 && clear_busy; w++) begin @(posedge CLOCK_50); #3; end
    check("pending_clear_done", 32'(clear_busy), 32'd0);
    run_stream(0, 0, 0, -1, -1);
    check("mem_zero_after_pending_clear", 32'(mem_diff()), 32'd0);

    // asynchronous reset in the middle of a stream with a clear pending
    for (int i = 0; i < DEPTH; i++) golden[i] = $urandom;
    load_mem();
    run_stream(1, 0, 0, 250, 300);
    #1; wr_req = 1'b1; disp_req = 1'b1; reset = 1'b1; #1;
    check_zero("reset_mid_stream");
    @(posedge CLOCK_50); #2; reset = 1'b0; wr_req = 1'b0; disp_req = 1'b0; #1;
    bad = 0;
    for (int w = 0; w < 8; w++) begin
      if (clear_busy || nn_busy || nn_valid || mem_we || disp_valid) bad++;
      @(posedge CLOCK_50); #3;
    end
    check("idle_after_reset", 32'(bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
